// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of alu_arbiter, bundled for port connection.
// The slave modport is the arbiter; master is whatever drives requests and models the ALU.
interface alu_arbiter_if;
  logic        req0_valid_i, req0_ready_o;
  logic [7:0]  req0_opcode_i;
  logic [31:0] req0_rs1_i, req0_rs2_i;
  logic        req1_valid_i, req1_ready_o;
  logic [7:0]  req1_opcode_i;
  logic [31:0] req1_rs1_i, req1_rs2_i;

  logic        rsp0_valid_o, rsp0_ready_i, rsp0_err_o;
  logic [63:0] rsp0_data_o;
  logic        rsp1_valid_o, rsp1_ready_i, rsp1_err_o;
  logic [63:0] rsp1_data_o;

  logic [7:0]  alu_opcode_o;
  logic [31:0] alu_data1_o, alu_data2_o;
  logic        alu_data1_valid_o, alu_data2_valid_o;
  logic        alu_start_o, alu_busy_i, alu_valid_i;
  logic [63:0] alu_data_i;
  logic [2:0]  state_o;

  modport slave (
    input  req0_valid_i, req0_opcode_i, req0_rs1_i, req0_rs2_i,
    input  req1_valid_i, req1_opcode_i, req1_rs1_i, req1_rs2_i,
    input  rsp0_ready_i, rsp1_ready_i,
    input  alu_busy_i, alu_valid_i, alu_data_i,
    output req0_ready_o, req1_ready_o,
    output rsp0_valid_o, rsp0_data_o, rsp0_err_o,
    output rsp1_valid_o, rsp1_data_o, rsp1_err_o,
    output alu_opcode_o, alu_data1_o, alu_data2_o,
    output alu_data1_valid_o, alu_data2_valid_o, alu_start_o, state_o
  );

  modport master (
    output req0_valid_i, req0_opcode_i, req0_rs1_i, req0_rs2_i,
    output req1_valid_i, req1_opcode_i, req1_rs1_i, req1_rs2_i,
    output rsp0_ready_i, rsp1_ready_i,
    output alu_busy_i, alu_valid_i, alu_data_i,
    input  req0_ready_o, req1_ready_o,
    input  rsp0_valid_o, rsp0_data_o, rsp0_err_o,
    input  rsp1_valid_o, rsp1_data_o, rsp1_err_o,
    input  alu_opcode_o, alu_data1_o, alu_data2_o,
    input  alu_data1_valid_o, alu_data2_valid_o, alu_start_o, state_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter between two requesters for one shared ALU, sequencing
// start/valid/busy and returning the result or an error on the granted response channel.
module alu_arbiter #(
  parameter int unsigned TIMEOUT_P = 1024
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  localparam logic [7:0]  OP_ADD   = 8'h01;
  localparam logic [7:0]  OP_MUL   = 8'h02;
  localparam logic [7:0]  OP_D1    = 8'hD1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_P - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

  state_e      state_q;
  logic        ptr_q, gnt_q;
  logic [7:0]  op_q;
  logic [31:0] rs1_q, rs2_q;
  logic        dvalid_q, start_q;
  logic [15:0] cnt_q;
  logic [63:0] data_q;
  logic        err_q, rsp0_valid_q, rsp1_valid_q;

  logic        arb_en, win0, win1, accept, legal;
  logic [7:0]  win_op;
  logic [31:0] win_rs1, win_rs2;

  // ptr_q=1 gives req1 priority when both requesters are valid
  always_comb begin
    arb_en  = (state_q == IDLE) && !bus.alu_busy_i;
    win0    = arb_en && bus.req0_valid_i && (!bus.req1_valid_i || !ptr_q);
    win1    = arb_en && bus.req1_valid_i && (!bus.req0_valid_i || ptr_q);
    accept  = win0 || win1;
    win_op  = win1 ? bus.req1_opcode_i : bus.req0_opcode_i;
    win_rs1 = win1 ? bus.req1_rs1_i    : bus.req0_rs1_i;
    win_rs2 = win1 ? bus.req1_rs2_i    : bus.req0_rs2_i;
    legal   = (win_op == OP_ADD) || (win_op == OP_MUL) || (win_op == OP_D1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      gnt_q        <= 1'b0;
      op_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      dvalid_q     <= 1'b0;
      start_q      <= 1'b0;
      cnt_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          gnt_q <= win1;
          ptr_q <= ~win1;
          op_q  <= win_op;
          rs1_q <= win_rs1;
          rs2_q <= win_rs2;
          if (legal) begin
            state_q  <= START;
            start_q  <= 1'b1;
            dvalid_q <= 1'b1;
          end else begin
            state_q      <= RESP;
            data_q       <= '0;
            err_q        <= 1'b1;
            rsp0_valid_q <= ~win1;
            rsp1_valid_q <= win1;
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          // a result arriving on the final timeout cycle still counts as success
          if (bus.alu_valid_i || cnt_q == TMO_LAST) begin
            state_q      <= RESP;
            dvalid_q     <= 1'b0;
            data_q       <= bus.alu_valid_i ? bus.alu_data_i : '0;
            err_q        <= ~bus.alu_valid_i;
            rsp0_valid_q <= ~gnt_q;
            rsp1_valid_q <= gnt_q;
          end
        end
        RESP: if (gnt_q ? bus.rsp1_ready_i : bus.rsp0_ready_i) begin
          state_q      <= IDLE;
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready_o      = win0;
  assign bus.req1_ready_o      = win1;
  assign bus.rsp0_valid_o      = rsp0_valid_q;
  assign bus.rsp1_valid_o      = rsp1_valid_q;
  assign bus.rsp0_data_o       = rsp0_valid_q ? data_q : '0;
  assign bus.rsp1_data_o       = rsp1_valid_q ? data_q : '0;
  assign bus.rsp0_err_o        = rsp0_valid_q & err_q;
  assign bus.rsp1_err_o        = rsp1_valid_q & err_q;
  assign bus.alu_opcode_o      = op_q;
  assign bus.alu_data1_o       = rs1_q;
  assign bus.alu_data2_o       = rs2_q;
  assign bus.alu_data1_valid_o = dvalid_q;
  assign bus.alu_data2_valid_o = dvalid_q;
  assign bus.alu_start_o       = start_q;
  assign bus.state_o           = {1'b0, state_q};

endmodule
